pmem_responder: RTL and testbench

Memory-side responder for the 16-bit-address / 128-bit-line physical memory interface used by the L2 cache. It accepts one line read or line write at a time, holds a line-granular backing array, and returns `pmem_resp` after a fixed, parameterised latency. It sits below the L2 cache datapath/control and replaces the behavioural memory model in synthesizable system builds and benches. It also provides busy, protocol-error and transaction-count observability.

---
 rtl/pmem_responder.sv | 147 ++++++++++++++
 tb/tb_pmem_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// Line-granular memory responder for the 16-bit-address / 128-bit-line pmem port.
// One request at a time. pmem_resp is driven from the edge E0+latency-1, so the initiator samples it at edge E0+latency.
module pmem_responder #(
  parameter int index_width = 12,
  parameter int latency     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         busy,
  output logic         proto_err,
  output logic [15:0]  read_count,
  output logic [15:0]  write_count,
  output logic [1:0]   state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESP    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(latency - 1);
  localparam int         LINES    = 1 << index_width;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [index_width-1:0] idx_q, idx_d;
  logic [127:0]           wdata_q, wdata_d;
  logic                   op_write_q, op_write_d;
  logic                   proto_err_q, proto_err_d;
  logic [15:0]            rcnt_q, rcnt_d;
  logic [15:0]            wcnt_q, wcnt_d;
  logic [127:0]           rdata_q;

  logic [127:0]           mem [LINES];

  logic                   abort;
  logic                   enter_resp;
  logic                   eff_write;
  logic [index_width-1:0] eff_idx;
  logic [127:0]           eff_wdata;
  logic [index_width-1:0] in_idx;
  logic                   unused_addr;

  // Byte-offset bits and any bits above the index only alias.
  assign unused_addr = ^pmem_address;
  assign in_idx      = pmem_address[3+index_width:4];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    op_write_d  = op_write_q;
    proto_err_d = proto_err_q;
    rcnt_d      = rcnt_q;
    wcnt_d      = wcnt_q;
    enter_resp  = 1'b0;
    eff_write   = op_write_q;
    eff_idx     = idx_q;
    eff_wdata   = wdata_q;
    abort       = op_write_q ? !pmem_write : !pmem_read;
    case (state_q)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          idx_d      = in_idx;
          wdata_d    = pmem_wdata;
          op_write_d = pmem_write;
          cnt_d      = CNT_INIT;
          if (pmem_read && pmem_write) proto_err_d = 1'b1;
          // With latency 1 the acceptance edge is also the RESP entry edge, so use the live inputs.
          if (latency == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
            eff_write  = pmem_write;
            eff_idx    = in_idx;
            eff_wdata  = pmem_wdata;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = RECOVER;
        if (op_write_q) wcnt_d = wcnt_q + 16'd1;
        else            rcnt_d = rcnt_q + 16'd1;
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      wdata_q     <= '0;
      op_write_q  <= 1'b0;
      proto_err_q <= 1'b0;
      rcnt_q      <= 16'd0;
      wcnt_q      <= 16'd0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      op_write_q  <= op_write_d;
      proto_err_q <= proto_err_d;
      rcnt_q      <= rcnt_d;
      wcnt_q      <= wcnt_d;
      if (enter_resp && !eff_write) rdata_q <= mem[eff_idx];
    end
  end

  // Array is never reset; a write is dropped if reset is high at its RESP entry edge.
  always_ff @(posedge clk) begin
    if (enter_resp && eff_write && !reset) mem[eff_idx] <= eff_wdata;
  end

  assign pmem_rdata  = rdata_q;
  assign pmem_resp   = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign proto_err   = proto_err_q;
  assign read_count  = rcnt_q;
  assign write_count = wcnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: dut0 uses latency 4 / 12 index bits, dut1 uses latency 1 / 4 index bits.
module tb_pmem_responder;
  localparam int W = 32 + 128;

  logic         clk = 1'b0;
  logic         reset;
  logic         rd    [2];
  logic         wr    [2];
  logic [15:0]  addr  [2];
  logic [127:0] wdata [2];
  logic [127:0] rdata [2];
  logic         resp  [2];
  logic         busy  [2];
  logic         perr  [2];
  logic [15:0]  rcnt  [2];
  logic [15:0]  wcnt  [2];
  logic [1:0]   st    [2];

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  // Entry: {cycle at which pmem_resp is seen after its edge, expected pmem_rdata}.
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [127:0] mdl [int];
  logic [127:0] last_rd [2];

  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D2 = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] D3 = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] D4 = 128'h0F0F_F0F0_1234_5678_9ABC_DEF0_0000_0001;
  localparam logic [127:0] D5 = 128'h5555_5555_5555_5555_0000_0000_0000_0010;
  localparam logic [127:0] D6 = 128'h6666_6666_7777_7777_8888_8888_9999_9999;
  localparam logic [127:0] D7 = 128'hCAFE_F00D_0000_0300_CAFE_F00D_0000_0300;
  localparam logic [127:0] D8 = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pmem_responder #(.index_width(12), .latency(4)) u_dut0 (
    .clk(clk), .reset(reset), .pmem_read(rd[0]), .pmem_write(wr[0]),
    .pmem_address(addr[0]), .pmem_wdata(wdata[0]), .pmem_rdata(rdata[0]),
    .pmem_resp(resp[0]), .busy(busy[0]), .proto_err(perr[0]),
    .read_count(rcnt[0]), .write_count(wcnt[0]), .state_o(st[0])
  );

  pmem_responder #(.index_width(4), .latency(1)) u_dut1 (
    .clk(clk), .reset(reset), .pmem_read(rd[1]), .pmem_write(wr[1]),
    .pmem_address(addr[1]), .pmem_wdata(wdata[1]), .pmem_rdata(rdata[1]),
    .pmem_resp(resp[1]), .busy(busy[1]), .proto_err(perr[1]),
    .read_count(rcnt[1]), .write_count(wcnt[1]), .state_o(st[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int key_of(input int d, input logic [15:0] a);
    return (d == 0) ? int'(a[15:4]) : (32'h10000 | int'(a[7:4]));
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pmem_resp pops one expected entry.
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    logic         have;
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (resp[d]) begin
          have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
          if (!have) begin
            n_checks++;
            n_fail++;
            $display("FAIL stray_resp dut%0d: got pmem_resp=1 at cycle %0d, expected none", d, cyc);
          end else begin
            if (d == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            check($sformatf("resp_cycle_dut%0d", d), 128'(cyc), 128'(e[W-1:128]));
            check($sformatf("rdata_dut%0d", d), rdata[d], e[127:0]);
          end
        end
      end
    end
  end

  task automatic wait_idle(input int d);
    int t;
    t = 0;
    while (busy[d] && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (busy[d]) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout dut%0d: got busy=1 after %0d cycles, expected 0", d, t);
    end
  endtask

  // Issue one request, scramble address/data after acceptance, hold it `extra` cycles past pmem_resp.
  task automatic op(input int d, input bit do_wr, input bit do_rd, input logic [15:0] a,
                    input logic [127:0] data, input int extra);
    int           n0, t;
    logic [127:0] er;
    logic [W-1:0] e;
    @(negedge clk);
    addr[d]  = a;
    wdata[d] = data;
    wr[d]    = do_wr;
    rd[d]    = do_rd;
    n0       = cyc + 1;
    if (do_wr) begin
      mdl[key_of(d, a)] = data;
      er = last_rd[d];
    end else begin
      er = mdl.exists(key_of(d, a)) ? mdl[key_of(d, a)] : '0;
      last_rd[d] = er;
    end
    // Response is driven after edge E(latency-1) and sampled by the initiator at E(latency).
    e = {32'(n0 + lat_of(d) - 1), er};
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    @(negedge clk);
    addr[d]  = ~a;
    wdata[d] = ~data;
    t = 1;
    while (!resp[d] && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!resp[d]) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_timeout dut%0d: got no pmem_resp within %0d cycles, expected one", d, t);
    end
    // Held request: RECOVER (busy), IDLE (not re-accepted), then re-accepted at E(latency+2).
    for (int k = 1; k <= extra; k++) begin
      @(negedge clk);
      check($sformatf("held_req_busy_k%0d", k), 128'(busy[d]), 128'(k != 2));
    end
    wr[d] = 1'b0;
    rd[d] = 1'b0;
    wait_idle(d);
  endtask

  task automatic abort_write(input int d, input logic [15:0] a, input logic [127:0] data, input int hold);
    logic [15:0] wc0;
    @(negedge clk);
    wc0      = wcnt[d];
    addr[d]  = a;
    wdata[d] = data;
    wr[d]    = 1'b1;
    repeat (hold) @(negedge clk);
    wr[d] = 1'b0;
    wait_idle(d);
    repeat (2) @(negedge clk);
    check("abort_write_count", 128'(wcnt[d]), 128'(wc0));
  endtask

  task automatic check_reset_vals(input int d, input string tag);
    check($sformatf("%s_resp_dut%0d", tag, d),  128'(resp[d]), 128'(0));
    check($sformatf("%s_busy_dut%0d", tag, d),  128'(busy[d]), 128'(0));
    check($sformatf("%s_perr_dut%0d", tag, d),  128'(perr[d]), 128'(0));
    check($sformatf("%s_rdata_dut%0d", tag, d), rdata[d], 128'(0));
    check($sformatf("%s_rcnt_dut%0d", tag, d),  128'(rcnt[d]), 128'(0));
    check($sformatf("%s_wcnt_dut%0d", tag, d),  128'(wcnt[d]), 128'(0));
    check($sformatf("%s_state_dut%0d", tag, d), 128'(st[d]),   128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test by time %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0; last_rd[d] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) check_reset_vals(d, "por");

    // No requests: stays idle, monitor flags any stray pmem_resp.
    repeat (6) @(negedge clk);
    check("idle_busy", 128'(busy[0]), 128'(0));

    // Write then read of the same line through a different byte offset.
    op(0, 1'b1, 1'b0, 16'h1230, D1, 0);
    op(0, 1'b0, 1'b1, 16'h123F, '0, 0);
    check("wr_rd_wcnt", 128'(wcnt[0]), 128'(1));
    check("wr_rd_rcnt", 128'(rcnt[0]), 128'(1));

    // Read held three cycles past resp: one response, re-acceptance then abort.
    op(0, 1'b0, 1'b1, 16'h1230, '0, 3);
    check("held_rcnt", 128'(rcnt[0]), 128'(2));

    // Aborted write leaves the line and count untouched.
    op(0, 1'b1, 1'b0, 16'h0040, D2, 0);
    abort_write(0, 16'h0040, D3, 2);
    op(0, 1'b0, 1'b1, 16'h0040, '0, 0);
    check("abort_wcnt", 128'(wcnt[0]), 128'(2));

    // Simultaneous read and write: write wins, sticky error.
    check("perr_before", 128'(perr[0]), 128'(0));
    op(0, 1'b1, 1'b1, 16'h0200, D4, 0);
    check("proto_perr", 128'(perr[0]), 128'(1));
    check("proto_rcnt", 128'(rcnt[0]), 128'(3));
    check("proto_wcnt", 128'(wcnt[0]), 128'(3));
    op(0, 1'b0, 1'b1, 16'h0200, '0, 0);
    check("proto_perr_sticky", 128'(perr[0]), 128'(1));

    // Latency 1 and 4-bit index aliasing.
    op(1, 1'b1, 1'b0, 16'h0010, D5, 0);
    op(1, 1'b1, 1'b0, 16'h0020, D6, 0);
    op(1, 0, 1'b1, 16'h0110, '0, 0);
    op(1, 0, 1'b1, 16'hFF20, '0, 0);
    check("lat1_wcnt", 128'(wcnt[1]), 128'(2));
    check("lat1_rcnt", 128'(rcnt[1]), 128'(2));

    // Asynchronous reset during an in-flight write discards it.
    op(0, 1'b1, 1'b0, 16'h0300, D7, 0);
    @(negedge clk);
    addr[0]  = 16'h0300;
    wdata[0] = D8;
    wr[0]    = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check_reset_vals(d, "async");
    wr[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    op(0, 1'b0, 1'b1, 16'h0300, '0, 0);
    check("post_reset_perr", 128'(perr[0]), 128'(0));

    repeat (3) @(negedge clk);
    check("queue0_drained", 128'(exp_q0.size()), 128'(0));
    check("queue1_drained", 128'(exp_q1.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
